// File: rtl/frame_step_sequencer.sv
// Once-per-frame update scheduler for the Pong datapath: collects ball-edge collision probes during the scan,
// then issues ball_step, waits for ball_ack (bounded), and issues paddle_step.
module frame_step_sequencer #(
    parameter int BALL_SIZE   = 8,
    parameter int TRIG_LINE   = 480,
    parameter int ACK_TIMEOUT = 15,
    parameter int SPEED_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       object_hit,
    input  logic [9:0] ballX,
    input  logic [9:0] ballY,
    input  logic       game_run,
    input  logic       ball_ack,
    output logic       ball_step,
    output logic       paddle_step,
    output logic       col_l,
    output logic       col_r,
    output logic       col_t,
    output logic       col_b,
    output logic [7:0] frame_cnt,
    output logic       overrun,
    output logic       ack_err
);

    localparam int TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [3:0]       DIV_LAST = 4'(SPEED_DIV - 1);
    localparam logic [10:0]      HALF     = 11'(BALL_SIZE / 2);
    localparam logic [10:0]      FULL     = 11'(BALL_SIZE);
    localparam logic [9:0]       TRIG_V   = 10'(TRIG_LINE);

    typedef enum logic [2:0] {
        SCAN,
        LATCH,
        BALL,
        WAIT_BALL,
        PADDLE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       probe;
    logic [3:0]       col;
    logic [3:0]       probe_hit;
    logic [3:0]       div;
    logic [TMO_W-1:0] tmo;
    logic             match;
    logic             match_q;
    logic             trig;
    logic             ack_timeout;

    // Probe coordinates are one bit wider than the counters so a point past 1023 can never alias.
    logic [10:0] hx, vy, bx, by, bx_mid, by_mid, bx_end, by_end;

    assign hx     = {1'b0, h_cnt};
    assign vy     = {1'b0, v_cnt};
    assign bx     = {1'b0, ballX};
    assign by     = {1'b0, ballY};
    assign bx_mid = bx + HALF;
    assign by_mid = by + HALF;
    assign bx_end = bx + FULL;
    assign by_end = by + FULL;

    assign probe_hit[3] = object_hit && (hx == bx)     && (vy == by_mid);
    assign probe_hit[2] = object_hit && (hx == bx_end) && (vy == by_mid);
    assign probe_hit[1] = object_hit && (hx == bx_mid) && (vy == by);
    assign probe_hit[0] = object_hit && (hx == bx_mid) && (vy == by_end);

    // Counts come from the slower pixel domain and hold for several clk cycles, so fire on the rising match only.
    assign match = (v_cnt == TRIG_V) && (h_cnt == 10'd0);
    assign trig  = match && !match_q;

    assign col_l = col[3];
    assign col_r = col[2];
    assign col_t = col[1];
    assign col_b = col[0];

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise an unassigned path infers a latch.
        state_next  = state;
        ball_step   = 1'b0;
        paddle_step = 1'b0;
        ack_timeout = 1'b0;
        case (state)
            SCAN: begin
                if (trig && (div == DIV_LAST)) state_next = LATCH;
            end
            LATCH: begin
                state_next = game_run ? BALL : SCAN;
            end
            BALL: begin
                ball_step  = 1'b1;
                state_next = WAIT_BALL;
            end
            WAIT_BALL: begin
                if (ball_ack) begin
                    state_next = PADDLE;
                end else if (tmo == TMO_LAST) begin
                    ack_timeout = 1'b1;
                    state_next  = PADDLE;
                end
            end
            PADDLE: begin
                paddle_step = 1'b1;
                state_next  = SCAN;
            end
            default: state_next = SCAN;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            match_q   <= 1'b0;
            probe     <= '0;
            col       <= '0;
            div       <= '0;
            tmo       <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            state   <= state_next;
            match_q <= match;

            if (trig) begin
                if (state == SCAN) begin
                    frame_cnt <= frame_cnt + 8'd1;
                    div       <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            // A hit landing in the LATCH cycle survives the clear and counts for the next step.
            probe <= ((state == LATCH) ? 4'b0000 : probe) | probe_hit;
            if (state == LATCH) col <= probe;

            tmo <= (state == WAIT_BALL) ? tmo + TMO_ONE : '0;
            if (ack_timeout) ack_err <= 1'b1;
        end
    end

endmodule
